// File: rtl/incr_result_fifo.sv
// Capture FIFO for incrementer results with a valid/ready drain port,
// plus a saturating running sum, a wrapping sample count and a sticky clamp flag.
module incr_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       clr,
    output logic [ACC_W-1:0]           acc,
    output logic [CNT_W-1:0]           cnt,
    output logic                       sat,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // the producer holds valid/data until accepted, and ready never looks at valid.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign in_ready  = (level != LVL_W'(DEPTH));
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem[rd_ptr];

    // Storage carries no reset; entries are only visible through level.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Clear is applied before the add, so clr with a push restarts from that sample.
    logic [ACC_W:0]   acc_base;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             sat_next;

    always_comb begin
        acc_base = clr ? '0 : {1'b0, acc};
        acc_sum  = acc_base + (ACC_W+1)'(in_data);
        acc_next = acc_base[ACC_W-1:0];
        cnt_next = clr ? '0 : cnt;
        sat_next = clr ? 1'b0 : sat;
        if (push) begin
            cnt_next = cnt_next + CNT_W'(1);
            if (acc_sum[ACC_W]) begin
                acc_next = '1;
                sat_next = 1'b1;
            end else begin
                acc_next = acc_sum[ACC_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            sat <= 1'b0;
        end else begin
            acc <= acc_next;
            cnt <= cnt_next;
            sat <= sat_next;
        end
    end

endmodule

// File: tb/tb_incr_result_fifo.sv
// Bench for incr_result_fifo: directed scenarios plus randomized traffic, checked
// by an expected-data queue and a plain-arithmetic model of acc/cnt/sat.
module tb_incr_result_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int ACC_W = 17;
    localparam int CNT_W = 8;
    localparam int LVL_W = 3;
    localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             clr;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    logic [LVL_W-1:0] level;

    incr_result_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .ACC_W(ACC_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .clr(clr),
        .acc(acc),
        .cnt(cnt),
        .sat(sat),
        .level(level)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] exp_q[$];
    longint           m_acc = 0;
    int               m_cnt = 0;
    bit               m_sat = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // output monitor: occupancy, flags and ordered data at every drain handshake
    always @(negedge clk) begin
        if (rst_n) begin
            check("level", 32'(level), 32'(exp_q.size()));
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("in_ready", 32'(in_ready), 32'(exp_q.size() != DEPTH));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL pop_empty: got out_data 0x%0h expected no entry at %0t", out_data, $time);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // acceptance side: compare counters, then record this cycle's transfer into the model
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            check("acc", 32'(acc), 32'(m_acc));
            check("cnt", 32'(cnt), 32'(m_cnt));
            check("sat", 32'(sat), 32'(m_sat));
            if (clr) begin
                m_acc = 0;
                m_cnt = 0;
                m_sat = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                m_acc = m_acc + longint'(in_data);
                if (m_acc > ACC_MAX) begin
                    m_acc = ACC_MAX;
                    m_sat = 1'b1;
                end
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
        end
    end

    // driver tasks
    task automatic push(input logic [WIDTH-1:0] d);
        int  n;
        bit  ok;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        do begin
            @(negedge clk);
            ok = in_ready;
            n++;
        end while (!ok && n < 50);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL push_timeout: got in_ready 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (level != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", 32'(level), 32'd0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        exp_q.delete();
        m_acc = 0;
        m_cnt = 0;
        m_sat = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got no end of test expected finish before 500000");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bit acc_now;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        clr       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_cnt", 32'(cnt), 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        rst_n = 1'b1;

        // single sample (a=14 upstream gives 15)
        push(16'd15);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'd15);
        check("single_level", 32'(level), 32'd1);
        check("single_acc", 32'(acc), 32'd15);
        check("single_cnt", 32'(cnt), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("single_drained_valid", 32'(out_valid), 32'd0);
        check("single_drained_level", 32'(level), 32'd0);

        // fill to full, fifth sample held off
        clr_pulse();
        for (int d = 1; d <= 4; d++) push(WIDTH'(d));
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_level", 32'(level), 32'd4);
        check("full_acc", 32'(acc), 32'd10);
        check("full_cnt", 32'(cnt), 32'd4);
        in_valid = 1'b1;
        in_data  = 16'd5;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("held_level", 32'(level), 32'd4);
        check("held_cnt", 32'(cnt), 32'd4);
        out_ready = 1'b1;
        push(16'd5);
        wait_empty();
        out_ready = 1'b0;

        // concurrent push/pop at level 2
        push(16'h0100);
        push(16'h0101);
        check("conc_start_level", 32'(level), 32'd2);
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            in_data   = WIDTH'(16'h0200 + i);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            check("conc_level", 32'(level), 32'd2);
        end
        in_valid = 1'b0;
        wait_empty();
        out_ready = 1'b0;

        // while full, a pop in the same cycle does not let a push through
        for (int i = 0; i < 4; i++) push(WIDTH'(16'h0300 + i));
        in_valid  = 1'b1;
        in_data   = 16'h0304;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("full_pop_only_level", 32'(level), 32'd3);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("full_then_both_level", 32'(level), 32'd3);
        wait_empty();
        out_ready = 1'b0;

        // saturation in a 17-bit accumulator
        clr_pulse();
        out_ready = 1'b1;
        push(16'hFFFF);
        push(16'hFFFF);
        check("sat2_acc", 32'(acc), 32'h1FFFE);
        check("sat2_flag", 32'(sat), 32'd0);
        push(16'h0003);
        check("sat3_acc", 32'(acc), 32'h1FFFF);
        check("sat3_flag", 32'(sat), 32'd1);
        clr = 1'b1;
        push(16'd7);
        clr = 1'b0;
        check("clr_push_acc", 32'(acc), 32'd7);
        check("clr_push_cnt", 32'(cnt), 32'd1);
        check("clr_push_sat", 32'(sat), 32'd0);

        // counter wrap
        clr_pulse();
        for (int i = 0; i < 256; i++) push(WIDTH'($urandom_range(0, 65535)));
        check("wrap_cnt_256", 32'(cnt), 32'd0);
        push(WIDTH'($urandom_range(0, 65535)));
        check("wrap_cnt_257", 32'(cnt), 32'd1);
        wait_empty();
        out_ready = 1'b0;

        // randomized traffic; an offered sample is held until accepted
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            acc_now = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (!in_valid || acc_now) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = WIDTH'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 15) == 0);
        end
        in_valid  = 1'b0;
        clr       = 1'b0;
        out_ready = 1'b1;
        wait_empty();
        out_ready = 1'b0;

        // asynchronous reset with three entries queued
        push(16'h0A01);
        push(16'h0A02);
        push(16'h0A03);
        check("pre_reset_level", 32'(level), 32'd3);
        reset_pulse();
        @(posedge clk);
        #1;
        push(16'd15);
        check("post_reset_valid", 32'(out_valid), 32'd1);
        check("post_reset_data", 32'(out_data), 32'd15);
        out_ready = 1'b1;
        wait_empty();
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
